axi_lite_write_slave: RTL and testbench



---
 rtl/axi_lite_write_slave_if.sv | 26 ++
 rtl/axi_lite_write_slave.sv | 87 ++++++++
 tb/tb_axi_lite_write_slave.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_write_slave_if.sv
// AXI4-Lite write channels (AW, W, B) between a write master and a write responder.
interface axi_lite_write_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write responder: holds one AW and one W beat, forwards in-window
// writes to a ready/valid register port and answers out-of-window ones with DECERR.
module axi_lite_write_slave #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_BASE  = '0,
  parameter longint unsigned         ADDR_SIZE  = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  axi_lite_write_slave_if.slave     s_axi,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [DATA_WIDTH/8-1:0]   out_strb,
  output logic [15:0]               decode_errors
);
  localparam int unsigned SW = DATA_WIDTH / 8;
  // One extra bit so ADDR_BASE+ADDR_SIZE cannot wrap at the top of the map.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(ADDR_SIZE);

  logic                  aw_full, w_full, in_win_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SW-1:0]         strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic [ADDR_WIDTH:0]   aw_ext;
  logic                  in_win, aw_hs, w_hs, commit, fire;

  assign aw_ext = {1'b0, s_axi.awaddr};
  assign in_win = (aw_ext >= WIN_LO) && (aw_ext < WIN_HI);

  assign s_axi.awready = !aw_full && !reset;
  assign s_axi.wready  = !w_full && !reset;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid && s_axi.wready;
  // B slot must be empty or draining this cycle before a new write may retire.
  assign commit = aw_full && w_full && (!bvalid_q || s_axi.bready);
  assign fire   = commit && (!in_win_q || out_ready);

  assign out_valid = commit && in_win_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_strb  = strb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      in_win_q      <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      decode_errors <= 16'd0;
    end else begin
      if (aw_hs) begin
        aw_full  <= 1'b1;
        addr_q   <= s_axi.awaddr;
        in_win_q <= in_win;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        data_q <= s_axi.wdata;
        strb_q <= s_axi.wstrb;
      end
      if (fire) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= in_win_q ? 2'b00 : 2'b11;
        if (!in_win_q && decode_errors != 16'hFFFF)
          decode_errors <= decode_errors + 16'd1;
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Scoreboard bench for axi_lite_write_slave: expected forwards and B responses are
// queued when a write is driven and checked when the DUT hands them over.
module tb_axi_lite_write_slave;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_strb;
  logic [15:0] decode_errors;

  int cmp = 0;
  int errs = 0;
  wr_t        exp_out[$];
  logic [1:0] exp_b[$];

  axi_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_write_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_BASE(32'h0), .ADDR_SIZE(4096)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_strb(out_strb), .decode_errors(decode_errors)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every forward and every B handshake must match the queue head.
  always @(negedge clk) begin
    wr_t e;
    logic [1:0] r;
    if (!reset) begin
      if (out_valid && out_ready) begin
        cmp++;
        if (exp_out.size() == 0) begin
          errs++;
          $display("FAIL out_unexpected: got addr=%h data=%h, required no forward", out_addr, out_data);
        end else begin
          e = exp_out.pop_front();
          if ({out_addr, out_data, out_strb} !== e) begin
            errs++;
            $display("FAIL out_payload: got %h/%h/%h, required %h/%h/%h",
                     out_addr, out_data, out_strb, e.addr, e.data, e.strb);
          end
        end
      end
      if (bus.bvalid && bus.bready) begin
        cmp++;
        if (exp_b.size() == 0) begin
          errs++;
          $display("FAIL b_unexpected: got bresp=%b, required no response", bus.bresp);
        end else begin
          r = exp_b.pop_front();
          if (bus.bresp !== r) begin
            errs++;
            $display("FAIL b_resp: got %b, required %b", bus.bresp, r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive AW and W together until both are accepted; expectations are queued up front.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit fwd);
    bit aw_pend = 1, w_pend = 1, aw_acc, w_acc;
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    if (fwd) exp_out.push_back(e);
    exp_b.push_back(fwd ? 2'b00 : 2'b11);
    bus.awvalid = 1; bus.awaddr = a;
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = s;
    for (int i = 0; i < 20 && (aw_pend || w_pend); i++) begin
      aw_acc = bus.awvalid && bus.awready;
      w_acc  = bus.wvalid && bus.wready;
      tick();
      if (aw_acc) begin bus.awvalid = 0; aw_pend = 0; end
      if (w_acc)  begin bus.wvalid = 0;  w_pend = 0;  end
    end
    cmp++;
    if (aw_pend || w_pend) begin
      errs++;
      $display("FAIL write_accept_timeout: got aw_pend=%0d w_pend=%0d, required 0/0", aw_pend, w_pend);
      bus.awvalid = 0; bus.wvalid = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    cmp++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.bresp, out_valid} !== 6'b0 ||
        decode_errors !== 16'd0 || {out_addr, out_data, out_strb} !== 68'd0) begin
      errs++;
      $display("FAIL reset_state: got aw/w/b/resp/ov=%b%b%b%b%b de=%0d, required all 0",
               bus.awready, bus.wready, bus.bvalid, bus.bresp, out_valid, decode_errors);
    end
    reset = 0;
    #1;
    cmp++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      errs++; $display("FAIL ready_after_reset: got %b, required 11", {bus.awready, bus.wready});
    end
  endtask

  task automatic test_same_cycle();
    out_ready = 1; bus.bready = 1;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 1);
    cmp++;
    if (out_valid !== 1'b1 || out_addr !== 32'h10 || bus.awready !== 1'b0) begin
      errs++; $display("FAIL same_cycle_fwd: got ov=%b addr=%h awready=%b, required 1/10/0", out_valid, out_addr, bus.awready);
    end
    tick();
    cmp++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || {bus.awready, bus.wready} !== 2'b11) begin
      errs++; $display("FAIL same_cycle_b: got bvalid=%b bresp=%b rdy=%b, required 1/00/11", bus.bvalid, bus.bresp, {bus.awready, bus.wready});
    end
    tick();
  endtask

  task automatic test_w_first();
    wr_t e;
    e.addr = 32'h20; e.data = 32'h12345678; e.strb = 4'h3;
    exp_out.push_back(e); exp_b.push_back(2'b00);
    bus.wvalid = 1; bus.wdata = e.data; bus.wstrb = e.strb;
    tick();
    bus.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      cmp++;
      if (bus.wready !== 1'b0 || out_valid !== 1'b0 || bus.awready !== 1'b1) begin
        errs++; $display("FAIL w_first_wait: got wready=%b ov=%b awready=%b, required 0/0/1", bus.wready, out_valid, bus.awready);
      end
      tick();
    end
    bus.awvalid = 1; bus.awaddr = e.addr;
    tick();
    bus.awvalid = 0;
    cmp++;
    if (out_valid !== 1'b1 || out_strb !== 4'h3) begin
      errs++; $display("FAIL w_first_fwd: got ov=%b strb=%h, required 1/3", out_valid, out_strb);
    end
    tick();
    cmp++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      errs++; $display("FAIL w_first_b: got %b/%b, required 1/00", bus.bvalid, bus.bresp);
    end
    tick();
  endtask

  task automatic test_decode();
    do_write(32'h1000, 32'hCAFEF00D, 4'hF, 0);
    cmp++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL decode_no_fwd: got ov=%b, required 0", out_valid);
    end
    tick();
    cmp++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b11 || decode_errors !== 16'd1) begin
      errs++; $display("FAIL decode_b: got bvalid=%b bresp=%b de=%0d, required 1/11/1", bus.bvalid, bus.bresp, decode_errors);
    end
    tick();
    do_write(32'hFFC, 32'h0BADF00D, 4'h0, 1);
    cmp++;
    if (out_valid !== 1'b1 || out_addr !== 32'hFFC || out_strb !== 4'h0) begin
      errs++; $display("FAIL edge_fwd: got ov=%b addr=%h strb=%h, required 1/ffc/0", out_valid, out_addr, out_strb);
    end
    tick();
    cmp++;
    if (bus.bresp !== 2'b00 || decode_errors !== 16'd1) begin
      errs++; $display("FAIL edge_b: got bresp=%b de=%0d, required 00/1", bus.bresp, decode_errors);
    end
    tick();
  endtask

  task automatic test_b_stall();
    bus.bready = 0;
    do_write(32'h40, 32'h11111111, 4'hF, 1);
    tick();
    do_write(32'h44, 32'h22222222, 4'hA, 1);
    for (int i = 0; i < 5; i++) begin
      cmp++;
      if (out_valid !== 1'b0 || bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
        errs++; $display("FAIL b_stall_hold: got ov=%b bvalid=%b awready=%b, required 0/1/0", out_valid, bus.bvalid, bus.awready);
      end
      tick();
    end
    bus.bready = 1;
    #1;
    cmp++;
    if (out_valid !== 1'b1 || out_addr !== 32'h44) begin
      errs++; $display("FAIL b_stall_commit: got ov=%b addr=%h, required 1/44", out_valid, out_addr);
    end
    tick();
    cmp++;
    if (bus.bvalid !== 1'b1) begin
      errs++; $display("FAIL b_stall_back2back: got bvalid=%b, required 1", bus.bvalid);
    end
    tick();
    cmp++;
    if (bus.bvalid !== 1'b0) begin
      errs++; $display("FAIL b_stall_drain: got bvalid=%b, required 0", bus.bvalid);
    end
  endtask

  task automatic test_out_stall();
    out_ready = 0;
    do_write(32'h80, 32'h55AA55AA, 4'h5, 1);
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if (out_valid !== 1'b1 || out_addr !== 32'h80 || out_data !== 32'h55AA55AA ||
          {bus.awready, bus.wready, bus.bvalid} !== 3'b000) begin
        errs++; $display("FAIL out_stall_hold: got ov=%b addr=%h data=%h rdy/b=%b, required 1/80/55aa55aa/000",
                         out_valid, out_addr, out_data, {bus.awready, bus.wready, bus.bvalid});
      end
      tick();
    end
    out_ready = 1;
    tick();
    cmp++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      errs++; $display("FAIL out_stall_b: got %b/%b, required 1/00", bus.bvalid, bus.bresp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.bready = 0;
    do_write(32'h100, 32'h1, 4'h1, 1);
    tick();
    do_write(32'h104, 32'h2, 4'h2, 1);
    reset = 1;
    #1;
    cmp++;
    if ({bus.awready, bus.wready} !== 2'b00) begin
      errs++; $display("FAIL reset_ready: got %b, required 00", {bus.awready, bus.wready});
    end
    exp_out.delete(); exp_b.delete();
    tick();
    reset = 0;
    bus.bready = 1;
    #1;
    cmp++;
    if (bus.bvalid !== 1'b0 || out_valid !== 1'b0 || decode_errors !== 16'd0 ||
        {bus.awready, bus.wready} !== 2'b11) begin
      errs++; $display("FAIL reset_mid_state: got bvalid=%b ov=%b de=%0d rdy=%b, required 0/0/0/11",
                       bus.bvalid, out_valid, decode_errors, {bus.awready, bus.wready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++;
      if (bus.bvalid !== 1'b0 || out_valid !== 1'b0) begin
        errs++; $display("FAIL reset_stale: got bvalid=%b ov=%b, required 0/0", bus.bvalid, out_valid);
      end
    end
  endtask

  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.wstrb = '0; bus.bready = 0; out_ready = 0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_decode();
    test_b_stall();
    test_out_stall();
    test_reset_mid();
    cmp++;
    if (exp_out.size() != 0 || exp_b.size() != 0) begin
      errs++; $display("FAIL scoreboard_drain: got %0d/%0d left, required 0/0", exp_out.size(), exp_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
